uart_rx_ctrl_param: RTL and testbench

Parametrised UART receive engine for the serial-protocol subsystem. It combines the control FSM and bit-level datapath for frames with configurable data width, runtime-selectable parity and 1 or 2 stop bits. Sampling is driven by an external oversampling tick. Received words are delivered over a valid/ready handshake, with per-word parity and framing status and an overrun indication. It sits between the baud-tick generator and the receive FIFO or host logic.

---
 rtl/uart_rx_ctrl_param_if.sv | 27 ++
 rtl/uart_rx_ctrl_param.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl_param.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_param_if.sv
// Receive-word handshake between the UART receive engine (master) and its consumer (slave).
// A word transfers on any clock where rx_valid and rx_ready are both high.
interface uart_rx_ctrl_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_ctrl_param.sv
// UART receive engine: oversampled start/data/parity/stop FSM with a valid/ready word output.
// Define UART_RX_BREAK_DETECT_EN to turn all-zero frames into a break_det pulse plus BREAK_WAIT.
module uart_rx_ctrl_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        baud_tick_i,
    input  logic                        rx_in_i,
    input  logic [1:0]                  par_mode_i,
    input  logic                        two_stop_i,
    uart_rx_ctrl_param_if.master        rx_if,
    output logic                        overrun_err_o,
    output logic                        busy_o,
    output logic                        break_det_o,
    output logic [2:0]                  dbg_state_o
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

`ifdef UART_RX_BREAK_DETECT_EN
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP1      = 3'd4,
        STOP2      = 3'd5,
        DELIVER    = 3'd6,
        BREAK_WAIT = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP1   = 3'd4,
        STOP2   = 3'd5,
        DELIVER = 3'd6
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [1:0]             par_mode_q, par_mode_d;
    logic                   two_stop_q, two_stop_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_out_q, perr_out_d;
    logic                   ferr_out_q, ferr_out_d;
    logic                   overrun_q, overrun_d;
    logic                   break_q, break_d;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                   par_bit_q, par_bit_d;
`endif

    logic          rx_s;
    logic          par_en;
    logic          par_odd;
    logic          sample;
    logic [TW-1:0] tick_adv;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign par_en   = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
    assign par_odd  = (par_mode_q == 2'b10);
    // Mid-bit sample point; the counter was re-aligned at the mid-start sample.
    assign sample   = baud_tick_i && (tick_q == TICK_LAST);
    assign tick_adv = !baud_tick_i ? tick_q :
                      (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            par_mode_q <= 2'b00;
            two_stop_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
            break_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_in_i};
            rx_prev_q  <= rx_s;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            par_mode_q <= par_mode_d;
            two_stop_q <= two_stop_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
            break_q    <= break_d;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_mode_d = par_mode_q;
        two_stop_d = two_stop_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = 1'b0;
        break_d    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        par_bit_d  = par_bit_q;
`endif

        if (valid_q && rx_if.rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    par_mode_d = par_mode_i;
                    two_stop_d = two_stop_i;
                    tick_d     = '0;
                    bit_d      = '0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_tick_i) begin
                    if (tick_q == TICK_HALF) begin
                        tick_d  = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                tick_d = tick_adv;
                if (sample) begin
                    shreg_d[bit_q] = rx_s;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = par_en ? PARITY : STOP1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                tick_d = tick_adv;
                if (sample) begin
                    perr_d  = rx_s != ((^shreg_q) ^ par_odd);
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_d = rx_s;
`endif
                    state_d = STOP1;
                end
            end
            STOP1: begin
                tick_d = tick_adv;
                if (sample) begin
                    ferr_d  = !rx_s;
                    state_d = two_stop_q ? STOP2 : DELIVER;
`ifdef UART_RX_BREAK_DETECT_EN
                    if (!rx_s && (shreg_q == '0) && (!par_en || !par_bit_q)) begin
                        break_d = 1'b1;
                        tick_d  = '0;
                        state_d = BREAK_WAIT;
                    end
`endif
                end
            end
            STOP2: begin
                tick_d = tick_adv;
                if (sample) begin
                    ferr_d  = ferr_q | !rx_s;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                // A word still waiting for its consumer wins; the new one is dropped.
                if (!valid_q || rx_if.rx_ready) begin
                    data_d     = shreg_q;
                    perr_out_d = perr_q;
                    ferr_out_d = ferr_q;
                    valid_d    = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
            end
`ifdef UART_RX_BREAK_DETECT_EN
            BREAK_WAIT: begin
                if (!rx_s) begin
                    tick_d = '0;
                end else if (baud_tick_i) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.parity_err = perr_out_q;
    assign rx_if.frame_err  = ferr_out_q;
    assign overrun_err_o    = overrun_q;
    assign break_det_o      = break_q;
    assign busy_o           = (state_q != IDLE);
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl_param.sv
// Bench for uart_rx_ctrl_param: directed frame table, corner-case sequences and random frames
// checked against a frame-level model and an expected-word queue.
`timescale 1ns/1ps
module tb_uart_rx_ctrl_param;

    localparam int DATA_BITS   = 8;
    localparam int OVERSAMPLE  = 16;
    localparam int SYNC_STAGES = 2;
    localparam int TICK_DIV    = 4;
    localparam int BIT_CLKS    = OVERSAMPLE * TICK_DIV;
    localparam int W           = DATA_BITS + 2;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_in     = 1'b1;
    logic [1:0] par_mode  = 2'b00;
    logic       two_stop  = 1'b0;
    logic       overrun_err;
    logic       busy;
    logic       break_det;
    logic [2:0] dbg_state;

    uart_rx_ctrl_param_if #(.DATA_BITS(DATA_BITS)) rx_if ();

    uart_rx_ctrl_param #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .baud_tick_i  (baud_tick),
        .rx_in_i      (rx_in),
        .par_mode_i   (par_mode),
        .two_stop_i   (two_stop),
        .rx_if        (rx_if.master),
        .overrun_err_o(overrun_err),
        .busy_o       (busy),
        .break_det_o  (break_det),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / reset / tick ----------------
    always #5 clock = ~clock;

    int tick_div_cnt = 0;
    initial begin
        forever begin
            @(posedge clock);
            #2;
            baud_tick    = (tick_div_cnt == TICK_DIV - 1);
            tick_div_cnt = (tick_div_cnt + 1) % TICK_DIV;
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp        = 0;
    int n_fail       = 0;
    int n_overrun    = 0;
    int n_break      = 0;
    int exp_breaks   = 0;
    int exp_overruns = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clock) begin
        if (overrun_err) n_overrun++;
        if (break_det) n_break++;
        if (!reset && rx_if.rx_valid && rx_if.rx_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_word: got data 0x%0h perr %0b ferr %0b, expected none",
                         rx_if.rx_data, rx_if.parity_err, rx_if.frame_err);
            end else begin
                check("word{ferr,perr,data}",
                      32'({rx_if.frame_err, rx_if.parity_err, rx_if.rx_data}),
                      32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    function automatic logic par_enabled(input logic [1:0] pm);
        return (pm == 2'b01) || (pm == 2'b10);
    endfunction

    function automatic logic par_bit_for(input logic [7:0] d, input logic [1:0] pm, input logic flip);
        // Even: bit makes total ones even (equals XOR of data); odd is the inverse.
        return (^d) ^ (pm == 2'b10) ^ flip;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                              input logic flip, input logic s1, input logic s2, input int gap_bits);
        par_mode = pm;
        two_stop = ts;
        rx_in    = 1'b0;
        step(BIT_CLKS / 2);
        par_mode = 2'($urandom_range(0, 3));
        two_stop = 1'($urandom_range(0, 1));
        step(BIT_CLKS - BIT_CLKS / 2);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx_in = d[i];
            step(BIT_CLKS);
        end
        if (par_enabled(pm)) begin
            rx_in = par_bit_for(d, pm, flip);
            step(BIT_CLKS);
        end
        rx_in = s1;
        step(BIT_CLKS);
        if (ts) begin
            rx_in = s2;
            step(BIT_CLKS);
        end
        rx_in = 1'b1;
        step(gap_bits * BIT_CLKS);
    endtask

    // Frame-level reference: what a consumer with rx_ready=1 should see for one frame.
    task automatic expect_frame(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                                input logic flip, input logic s1, input logic s2);
        logic perr;
        logic ferr;
`ifdef UART_RX_BREAK_DETECT_EN
        if (d == 8'h00 && !s1 && (!par_enabled(pm) || !par_bit_for(d, pm, flip))) begin
            exp_breaks++;
            return;
        end
`endif
        perr = par_enabled(pm) && flip;
        ferr = !s1 || (ts && !s2);
        exp_q.push_back({ferr, perr, d});
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] data;
        logic [1:0] pmode;
        logic       ts;
        logic       flip;
        logic       s1;
        logic       s2;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] d;
        logic [1:0] pm;
        logic       ts, flip, s1, s2;

        vecs[0] = '{8'hA5, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[3] = '{8'h0F, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b1};
        vecs[4] = '{8'h55, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};

        rx_if.rx_ready = 1'b1;
        step(3);
        check("reset_valid", 32'(rx_if.rx_valid), 32'd0);
        check("reset_data", 32'(rx_if.rx_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_flags", 32'({rx_if.parity_err, rx_if.frame_err, overrun_err, break_det}), 32'd0);
        reset = 1'b0;
        step(2 * BIT_CLKS);

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({vecs[i].exp_ferr, vecs[i].exp_perr, vecs[i].exp_data});
            send_frame(vecs[i].data, vecs[i].pmode, vecs[i].ts, vecs[i].flip,
                       vecs[i].s1, vecs[i].s2, 1);
            check($sformatf("vec%0d_delivered", i), 32'(exp_q.size()), 32'd0);
        end

        // Overrun: second frame is dropped while the first is still held.
        rx_if.rx_ready = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 8'h11});
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        exp_overruns++;
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        check("overrun_held_data", 32'(rx_if.rx_data), 32'h11);
        check("overrun_held_valid", 32'(rx_if.rx_valid), 32'd1);
        check("overrun_pulses", 32'(n_overrun), 32'(exp_overruns));
        rx_if.rx_ready = 1'b1;
        step(3);
        check("overrun_valid_falls", 32'(rx_if.rx_valid), 32'd0);
        check("overrun_drained", 32'(exp_q.size()), 32'd0);

        // False start: short low glitch.
        rx_in = 1'b0;
        step(OVERSAMPLE / 4 * TICK_DIV);
        rx_in = 1'b1;
        check("false_start_busy", 32'(busy), 32'd1);
        step(BIT_CLKS);
        check("false_start_idle", 32'(busy), 32'd0);

        // Reset in the middle of an 0xFF frame.
        rx_in = 1'b0;
        step(BIT_CLKS);
        rx_in = 1'b1;
        step(3 * BIT_CLKS);
        check("mid_frame_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step(1);
        check("mid_reset_data", 32'(rx_if.rx_data), 32'd0);
        check("mid_reset_outputs",
              32'({rx_if.rx_valid, busy, rx_if.parity_err, rx_if.frame_err, overrun_err, break_det}),
              32'd0);
        reset = 1'b0;
        step(2 * BIT_CLKS);
        expect_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        check("after_reset_delivered", 32'(exp_q.size()), 32'd0);

        // Line held low for two frame times.
        par_mode = 2'b00;
        two_stop = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        exp_breaks++;
`else
        exp_q.push_back({1'b1, 1'b0, 8'h00});
`endif
        rx_in = 1'b0;
        step(20 * BIT_CLKS);
`ifdef UART_RX_BREAK_DETECT_EN
        check("break_busy_low_line", 32'(busy), 32'd1);
        check("break_pulses", 32'(n_break), 32'(exp_breaks));
        rx_in = 1'b1;
        step(BIT_CLKS / 2);
        check("break_busy_until_high", 32'(busy), 32'd1);
        step(BIT_CLKS);
        check("break_released", 32'(busy), 32'd0);
`else
        check("break_as_frame_idle", 32'(busy), 32'd0);
        rx_in = 1'b1;
        step(2 * BIT_CLKS);
`endif
        check("break_words", 32'(exp_q.size()), 32'd0);

        // Random frames against the frame-level model.
        for (int i = 0; i < 16; i++) begin
            d    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            pm   = 2'($urandom_range(0, 3));
            ts   = 1'($urandom_range(0, 1));
            flip = 1'($urandom_range(0, 1));
            s1   = ($urandom_range(0, 3) != 0);
            s2   = ($urandom_range(0, 3) != 0);
            expect_frame(d, pm, ts, flip, s1, s2);
            send_frame(d, pm, ts, flip, s1, s2, 2);
            check($sformatf("rand%0d_delivered", i), 32'(exp_q.size()), 32'd0);
        end

        check("total_overruns", 32'(n_overrun), 32'(exp_overruns));
        check("total_breaks", 32'(n_break), 32'(exp_breaks));
        check("final_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
